// File: rtl/pbs_pkg.sv
// Shared definitions for the turn-based battle engine.
//  - State encodings (4-bit) for the battle FSM.
//  - Outcome codes and small decode helpers used by the top level.
package pbs_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_P_LOAD  = 4'd1;
  localparam logic [3:0] ST_P_CALC  = 4'd2;
  localparam logic [3:0] ST_P_APPLY = 4'd3;
  localparam logic [3:0] ST_A_LOAD  = 4'd4;
  localparam logic [3:0] ST_A_CALC  = 4'd5;
  localparam logic [3:0] ST_A_APPLY = 4'd6;
  localparam logic [3:0] ST_VICTORY = 4'd7;
  localparam logic [3:0] ST_LOSS    = 4'd8;
  localparam logic [3:0] ST_DRAW    = 4'd9;

  localparam logic [1:0] OUT_NONE    = 2'd0;
  localparam logic [1:0] OUT_VICTORY = 2'd1;
  localparam logic [1:0] OUT_LOSS    = 2'd2;
  localparam logic [1:0] OUT_DRAW    = 2'd3;

  // Outcome carried by a state; OUT_NONE for every non-terminal state.
  function automatic logic [1:0] outcome_of(input logic [3:0] st);
    case (st)
      ST_VICTORY: outcome_of = OUT_VICTORY;
      ST_LOSS:    outcome_of = OUT_LOSS;
      ST_DRAW:    outcome_of = OUT_DRAW;
      default:    outcome_of = OUT_NONE;
    endcase
  endfunction

  // Battle in progress: anything that is neither IDLE nor terminal.
  function automatic logic is_busy(input logic [3:0] st);
    is_busy = (st != ST_IDLE) && (outcome_of(st) == OUT_NONE);
  endfunction

endpackage

// File: rtl/dmg_calc.sv
// Damage calculator shared by both sides through an attacker mux.
//  clk, resetn : clock, synchronous active-low reset
//  en          : capture pow*atk this cycle (asserted in a CALC state)
//  pow, atk    : attacker's move power and attack stat
//  dmg         : (pow*atk) >> DMG_SHIFT, saturated to HP_W bits; holds
//                the last captured value until the next capture
module dmg_calc
  import pbs_pkg::*;
#(
  parameter int HP_W      = 8,
  parameter int POW_W     = 6,
  parameter int ATK_W     = 4,
  parameter int DMG_SHIFT = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [POW_W-1:0] pow,
  input  logic [ATK_W-1:0] atk,
  output logic [HP_W-1:0]  dmg
);

  localparam int PROD_W = POW_W + ATK_W;

  logic [PROD_W-1:0]      prod_q, prod_d;
  logic [PROD_W-1:0]      shifted;
  // Compare in a width wide enough for both operands so that any
  // combination of HP_W and PROD_W saturates correctly.
  logic [PROD_W+HP_W-1:0] shifted_ext;
  logic [PROD_W+HP_W-1:0] hp_max_ext;

  always_comb begin
    prod_d = prod_q;
    if (en) begin
      prod_d = PROD_W'(pow) * PROD_W'(atk);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  always_comb begin
    shifted     = prod_q >> DMG_SHIFT;
    shifted_ext = {{HP_W{1'b0}}, shifted};
    hp_max_ext  = {{PROD_W{1'b0}}, {HP_W{1'b1}}};
    dmg         = (shifted_ext > hp_max_ext) ? {HP_W{1'b1}} : shifted_ext[HP_W-1:0];
  end

endmodule

// File: rtl/battle_turn_engine.sv
// One complete player-vs-AI battle: load move, calculate damage, apply it
// to the defender with saturation, then pick the next turn or an outcome.
//  clk, resetn           : clock, synchronous active-low reset
//  start                 : latch init HP, stats, ai_first; (re)start battle
//  go                    : leave a LOAD state, latching that side's power
//  ai_first              : AI attacks first in every round
//  p_/a_hp_init, _atk    : initial HP and attack stats (latched at start)
//  p_/a_pow              : move power (latched on go in the owner's LOAD)
//  p_hp, a_hp, dmg       : current HP and last computed damage
//  dmg_valid             : high for the single APPLY cycle
//  turn_count            : completed rounds
//  state, busy, victory, loss, draw : status, decoded from the state reg
module battle_turn_engine
  import pbs_pkg::*;
#(
  parameter int HP_W      = 8,
  parameter int POW_W     = 6,
  parameter int ATK_W     = 4,
  parameter int DMG_SHIFT = 2,
  parameter int MAX_TURNS = 16,
  localparam int TURN_W   = $clog2(MAX_TURNS + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              go,
  input  logic              ai_first,
  input  logic [HP_W-1:0]   p_hp_init,
  input  logic [HP_W-1:0]   a_hp_init,
  input  logic [ATK_W-1:0]  p_atk,
  input  logic [ATK_W-1:0]  a_atk,
  input  logic [POW_W-1:0]  p_pow,
  input  logic [POW_W-1:0]  a_pow,
  output logic [HP_W-1:0]   p_hp,
  output logic [HP_W-1:0]   a_hp,
  output logic [HP_W-1:0]   dmg,
  output logic              dmg_valid,
  output logic [TURN_W-1:0] turn_count,
  output logic [3:0]        state,
  output logic              busy,
  output logic              victory,
  output logic              loss,
  output logic              draw
);

  localparam logic [TURN_W-1:0] MAX_T = TURN_W'(MAX_TURNS);

  logic [3:0]        state_q, state_d;
  logic [HP_W-1:0]   p_hp_q, p_hp_d, a_hp_q, a_hp_d;
  logic [ATK_W-1:0]  p_atk_q, p_atk_d, a_atk_q, a_atk_d;
  logic [POW_W-1:0]  pow_q, pow_d;
  logic              ai_first_q, ai_first_d;
  logic [TURN_W-1:0] turn_q, turn_d;

  logic              calc_en;
  logic [ATK_W-1:0]  calc_atk;
  logic [HP_W-1:0]   dmg_w;
  logic [HP_W-1:0]   def_hp, hp_after;
  logic              round_end;
  logic [TURN_W-1:0] turn_inc;

  // Only one side is ever in CALC, so one power register and an atk mux
  // are enough to feed the shared calculator.
  assign calc_en  = (state_q == ST_P_CALC) || (state_q == ST_A_CALC);
  assign calc_atk = (state_q == ST_A_CALC) ? a_atk_q : p_atk_q;

  dmg_calc #(
    .HP_W      (HP_W),
    .POW_W     (POW_W),
    .ATK_W     (ATK_W),
    .DMG_SHIFT (DMG_SHIFT)
  ) u_dmg_calc (
    .clk    (clk),
    .resetn (resetn),
    .en     (calc_en),
    .pow    (pow_q),
    .atk    (calc_atk),
    .dmg    (dmg_w)
  );

  always_comb begin
    def_hp    = (state_q == ST_A_APPLY) ? p_hp_q : a_hp_q;
    hp_after  = (def_hp > dmg_w) ? (def_hp - dmg_w) : '0;
    // The round closes on whichever side attacks second.
    round_end = (state_q == ST_P_APPLY) ? ai_first_q : !ai_first_q;
    turn_inc  = turn_q + TURN_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    p_hp_d     = p_hp_q;
    a_hp_d     = a_hp_q;
    p_atk_d    = p_atk_q;
    a_atk_d    = a_atk_q;
    pow_d      = pow_q;
    ai_first_d = ai_first_q;
    turn_d     = turn_q;
    case (state_q)
      ST_IDLE, ST_VICTORY, ST_LOSS, ST_DRAW: begin
        if (start) begin
          p_hp_d     = p_hp_init;
          a_hp_d     = a_hp_init;
          p_atk_d    = p_atk;
          a_atk_d    = a_atk;
          ai_first_d = ai_first;
          turn_d     = '0;
          state_d    = ai_first ? ST_A_LOAD : ST_P_LOAD;
        end
      end
      ST_P_LOAD: begin
        if (go) begin
          pow_d   = p_pow;
          state_d = ST_P_CALC;
        end
      end
      ST_A_LOAD: begin
        if (go) begin
          pow_d   = a_pow;
          state_d = ST_A_CALC;
        end
      end
      ST_P_CALC: state_d = ST_P_APPLY;
      ST_A_CALC: state_d = ST_A_APPLY;
      ST_P_APPLY, ST_A_APPLY: begin
        if (state_q == ST_P_APPLY) begin
          a_hp_d = hp_after;
        end else begin
          p_hp_d = hp_after;
        end
        if (hp_after == '0) begin
          state_d = (state_q == ST_P_APPLY) ? ST_VICTORY : ST_LOSS;
        end else if (round_end) begin
          turn_d  = turn_inc;
          state_d = (turn_inc == MAX_T) ? ST_DRAW
                  : (ai_first_q ? ST_A_LOAD : ST_P_LOAD);
        end else begin
          state_d = (state_q == ST_P_APPLY) ? ST_A_LOAD : ST_P_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      p_hp_q     <= '0;
      a_hp_q     <= '0;
      p_atk_q    <= '0;
      a_atk_q    <= '0;
      pow_q      <= '0;
      ai_first_q <= 1'b0;
      turn_q     <= '0;
    end else begin
      state_q    <= state_d;
      p_hp_q     <= p_hp_d;
      a_hp_q     <= a_hp_d;
      p_atk_q    <= p_atk_d;
      a_atk_q    <= a_atk_d;
      pow_q      <= pow_d;
      ai_first_q <= ai_first_d;
      turn_q     <= turn_d;
    end
  end

  assign p_hp       = p_hp_q;
  assign a_hp       = a_hp_q;
  assign dmg        = dmg_w;
  assign dmg_valid  = (state_q == ST_P_APPLY) || (state_q == ST_A_APPLY);
  assign turn_count = turn_q;
  assign state      = state_q;
  assign busy       = is_busy(state_q);
  assign victory    = (outcome_of(state_q) == OUT_VICTORY);
  assign loss       = (outcome_of(state_q) == OUT_LOSS);
  assign draw       = (outcome_of(state_q) == OUT_DRAW);

endmodule

// File: tb/tb_battle_turn_engine.sv
// Directed bench: u_dut uses default parameters, u_dut3 uses MAX_TURNS = 3
// for the draw case. Both see the same stimulus.
module tb_battle_turn_engine;
  import pbs_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       go = 1'b0;
  logic       ai_first = 1'b0;
  logic [7:0] p_hp_init = '0, a_hp_init = '0;
  logic [3:0] p_atk = '0, a_atk = '0;
  logic [5:0] p_pow = '0, a_pow = '0;

  logic [7:0] p_hp, a_hp, dmg;
  logic       dmg_valid, busy, victory, loss, draw;
  logic [4:0] turn_count;
  logic [3:0] state;

  logic [7:0] p_hp3, a_hp3, dmg3;
  logic       dmg_valid3, busy3, victory3, loss3, draw3;
  logic [1:0] turn_count3;
  logic [3:0] state3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  battle_turn_engine u_dut (
    .clk(clk), .resetn(resetn), .start(start), .go(go), .ai_first(ai_first),
    .p_hp_init(p_hp_init), .a_hp_init(a_hp_init), .p_atk(p_atk), .a_atk(a_atk),
    .p_pow(p_pow), .a_pow(a_pow), .p_hp(p_hp), .a_hp(a_hp), .dmg(dmg),
    .dmg_valid(dmg_valid), .turn_count(turn_count), .state(state),
    .busy(busy), .victory(victory), .loss(loss), .draw(draw)
  );

  battle_turn_engine #(.MAX_TURNS(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .start(start), .go(go), .ai_first(ai_first),
    .p_hp_init(p_hp_init), .a_hp_init(a_hp_init), .p_atk(p_atk), .a_atk(a_atk),
    .p_pow(p_pow), .a_pow(a_pow), .p_hp(p_hp3), .a_hp(a_hp3), .dmg(dmg3),
    .dmg_valid(dmg_valid3), .turn_count(turn_count3), .state(state3),
    .busy(busy3), .victory(victory3), .loss(loss3), .draw(draw3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) resetn = 1'b0;
    @(negedge clk);
    @(negedge clk) resetn = 1'b1;
    $display("reset");
  endtask

  task automatic setup(input logic [7:0] ph, input logic [7:0] ah, input logic [3:0] pa,
                       input logic [3:0] aa, input logic [5:0] pp, input logic [5:0] ap,
                       input logic af);
    p_hp_init = ph; a_hp_init = ah; p_atk = pa; a_atk = aa;
    p_pow = pp; a_pow = ap; ai_first = af;
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    $display("start: state=%0d p_hp=%0d a_hp=%0d", state, p_hp, a_hp);
  endtask

  // One attack: go in LOAD, then CALC, APPLY, and the cycle after APPLY.
  // With extra_go, go stays high through CALC and APPLY as well.
  task automatic do_turn(input string who, input logic extra_go, input logic [7:0] exp_dmg);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = extra_go;
    @(negedge clk);
    check({who, " dmg_valid"}, {31'd0, dmg_valid}, 32'd1);
    check({who, " dmg"}, {24'd0, dmg}, {24'd0, exp_dmg});
    @(negedge clk) go = 1'b0;
    check({who, " dmg_valid low"}, {31'd0, dmg_valid}, 32'd0);
    $display("turn %s: dmg=%0d p_hp=%0d a_hp=%0d state=%0d turns=%0d",
             who, dmg, p_hp, a_hp, state, turn_count);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst state", {28'd0, state}, {28'd0, ST_IDLE});
    check("rst p_hp", {24'd0, p_hp}, 32'd0);
    check("rst a_hp", {24'd0, a_hp}, 32'd0);
    check("rst dmg", {24'd0, dmg}, 32'd0);
    check("rst turns", {27'd0, turn_count}, 32'd0);
    check("rst flags", {27'd0, dmg_valid, busy, victory, loss, draw}, 32'd0);
    resetn = 1'b1;

    // Player first, 4 dmg per hit: player wins on its 5th hit
    setup(8'd20, 8'd20, 4'd2, 4'd2, 6'd8, 6'd8, 1'b0);
    do_start();
    check("t1 state", {28'd0, state}, {28'd0, ST_P_LOAD});
    check("t1 p_hp", {24'd0, p_hp}, 32'd20);
    check("t1 a_hp", {24'd0, a_hp}, 32'd20);
    check("t1 busy", {31'd0, busy}, 32'd1);
    for (int r = 0; r < 4; r++) begin
      do_turn("P", 1'b0, 8'd4);
      do_turn("A", (r == 0), 8'd4);
      if (r == 0) begin
        check("go ignored", {28'd0, state}, {28'd0, ST_P_LOAD});
        @(negedge clk);
        check("go not queued", {28'd0, state}, {28'd0, ST_P_LOAD});
        check("round1 turns", {27'd0, turn_count}, 32'd1);
      end
    end
    check("t1 mid turns", {27'd0, turn_count}, 32'd4);
    check("t1 mid p_hp", {24'd0, p_hp}, 32'd4);
    check("t1 mid a_hp", {24'd0, a_hp}, 32'd4);
    p_hp_init = 8'd99;
    do_start();
    check("start ignored state", {28'd0, state}, {28'd0, ST_P_LOAD});
    check("start ignored p_hp", {24'd0, p_hp}, 32'd4);
    p_hp_init = 8'd20;
    do_turn("P", 1'b0, 8'd4);
    check("t1 end state", {28'd0, state}, {28'd0, ST_VICTORY});
    check("t1 victory", {28'd0, busy, victory, loss, draw}, 32'b0100);
    check("t1 end a_hp", {24'd0, a_hp}, 32'd0);
    check("t1 end p_hp", {24'd0, p_hp}, 32'd4);
    check("t1 end turns", {27'd0, turn_count}, 32'd4);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("go in terminal", {28'd0, state}, {28'd0, ST_VICTORY});

    // AI first: AI wins, restarted straight from VICTORY
    setup(8'd20, 8'd20, 4'd2, 4'd2, 6'd8, 6'd8, 1'b1);
    do_start();
    check("t2 state", {28'd0, state}, {28'd0, ST_A_LOAD});
    check("t2 turns", {27'd0, turn_count}, 32'd0);
    check("t2 a_hp", {24'd0, a_hp}, 32'd20);
    for (int r = 0; r < 4; r++) begin
      do_turn("A", 1'b0, 8'd4);
      do_turn("P", 1'b0, 8'd4);
    end
    do_turn("A", 1'b0, 8'd4);
    check("t2 end state", {28'd0, state}, {28'd0, ST_LOSS});
    check("t2 loss", {28'd0, busy, victory, loss, draw}, 32'b0010);
    check("t2 p_hp", {24'd0, p_hp}, 32'd0);
    check("t2 a_hp", {24'd0, a_hp}, 32'd4);

    // Saturation: 63*15=945, >>2 = 236; HP 5 clamps to 0
    setup(8'd5, 8'd5, 4'd15, 4'd15, 6'd63, 6'd63, 1'b0);
    do_start();
    do_turn("P", 1'b0, 8'd236);
    check("t3 state", {28'd0, state}, {28'd0, ST_VICTORY});
    check("t3 a_hp", {24'd0, a_hp}, 32'd0);
    check("t3 p_hp", {24'd0, p_hp}, 32'd5);

    // Draw with MAX_TURNS = 3 and zero power
    do_reset();
    setup(8'd20, 8'd20, 4'd2, 4'd2, 6'd0, 6'd0, 1'b0);
    do_start();
    for (int r = 0; r < 3; r++) begin
      do_turn("P", 1'b0, 8'd0);
      do_turn("A", 1'b0, 8'd0);
    end
    check("t4 state3", {28'd0, state3}, {28'd0, ST_DRAW});
    check("t4 flags3", {28'd0, busy3, victory3, loss3, draw3}, 32'b0001);
    check("t4 turns3", {30'd0, turn_count3}, 32'd3);
    check("t4 p_hp3", {24'd0, p_hp3}, 32'd20);
    check("t4 a_hp3", {24'd0, a_hp3}, 32'd20);
    check("t4 dmg3", {24'd0, dmg3}, 32'd0);
    check("t4 default state", {28'd0, state}, {28'd0, ST_P_LOAD});
    check("t4 default turns", {27'd0, turn_count}, 32'd3);

    // Reset during A_CALC, then a clean restart
    do_reset();
    setup(8'd20, 8'd20, 4'd2, 4'd2, 6'd8, 6'd8, 1'b0);
    do_start();
    do_turn("P", 1'b0, 8'd4);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("t5 in A_CALC", {28'd0, state}, {28'd0, ST_A_CALC});
    resetn = 1'b0;
    @(negedge clk);
    check("t5 rst state", {28'd0, state}, {28'd0, ST_IDLE});
    check("t5 rst hp", {16'd0, p_hp, a_hp}, 32'd0);
    check("t5 rst dmg", {24'd0, dmg}, 32'd0);
    check("t5 rst flags", {27'd0, dmg_valid, busy, victory, loss, draw}, 32'd0);
    resetn = 1'b1;
    $display("reset during A_CALC");
    do_start();
    check("t5 restart state", {28'd0, state}, {28'd0, ST_P_LOAD});
    check("t5 restart hp", {16'd0, p_hp, a_hp}, {16'd0, 8'd20, 8'd20});
    check("t5 restart turns", {27'd0, turn_count}, 32'd0);
    do_turn("P", 1'b0, 8'd4);
    check("t5 a_hp", {24'd0, a_hp}, 32'd16);
    check("t5 next state", {28'd0, state}, {28'd0, ST_A_LOAD});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
